// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins by default; fetch is forced through after STARVE_LIMIT bypasses. Define ARB_PERF_CNT_EN for grant/conflict counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | arbitrate between if_req and d_req
//   GRANT_I  | fetch access on the memory, waiting for mem_ack
//   GRANT_D  | data access on the memory, waiting for mem_ack
//   RESP     | one-cycle ready pulse to the granted requester
module unified_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
`ifdef ARB_PERF_CNT_EN
   ,output logic [31:0]   perf_if_grants,
    output logic [31:0]   perf_d_grants,
    output logic [31:0]   perf_conflicts
`endif
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_I = 2'd1;
    localparam logic [1:0] ST_GRANT_D = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [SCW-1:0] starve_q, starve_d;
    logic           mem_req_q, mem_req_d;
    logic           mem_we_q, mem_we_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]  if_rdata_q, if_rdata_d;
    logic [DW-1:0]  d_rdata_q, d_rdata_d;
    logic           if_ready_q, if_ready_d;
    logic           d_ready_q, d_ready_d;

    logic in_idle, data_win, grant_d_fire, grant_i_fire;

    // Fetch only overrides data once it has been bypassed STARVE_LIMIT times in a row.
    assign in_idle      = (state_q == ST_IDLE);
    assign data_win     = d_req && !(if_req && (starve_q == STARVE_MAX));
    assign grant_d_fire = in_idle && data_win;
    assign grant_i_fire = in_idle && !data_win && if_req;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_d_fire) begin
                    state_d     = ST_GRANT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (!if_req)
                        starve_d = '0;
                    else if (starve_q != STARVE_MAX)
                        starve_d = starve_q + 1'b1;
                end else if (grant_i_fire) begin
                    state_d     = ST_GRANT_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            ST_GRANT_I: begin
                if (mem_ack) begin
                    state_d    = ST_RESP;
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_ready_d = 1'b1;
                end
            end
            ST_GRANT_D: begin
                if (mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    d_ready_d = 1'b1;
                    if (!mem_we_q)
                        d_rdata_d = mem_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_d_q, perf_cf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_if_q <= '0;
            perf_d_q  <= '0;
            perf_cf_q <= '0;
        end else begin
            if (grant_i_fire)
                perf_if_q <= perf_if_q + 32'd1;
            if (grant_d_fire)
                perf_d_q <= perf_d_q + 32'd1;
            if (in_idle && if_req && d_req)
                perf_cf_q <= perf_cf_q + 32'd1;
        end
    end

    assign perf_if_grants = perf_if_q;
    assign perf_d_grants  = perf_d_q;
    assign perf_conflicts = perf_cf_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed protocol cases, starvation, then random traffic.
// Inputs change 1 time unit after posedge; everything is sampled on negedge.
module tb_unified_mem_arbiter;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_grants, perf_d_grants, perf_conflicts;
`endif

    unified_mem_arbiter #(.STARVE_LIMIT(SL), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef ARB_PERF_CNT_EN
       ,.perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit          st;
        logic [31:0] v;
    } dexp_t;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];
    logic [31:0] exp_if_q [$];
    dexp_t       exp_d_q [$];
    bit          glog [$];
    int          grant_cnt = 0;
    int          fix_k = -1;
    bit          resp_en = 1'b1;
    logic        force_ack = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (i == 16) return 32'h2008_0005;
        return {b, 8'hA5, ~b, 8'h3C};
    endfunction

    // Memory model: acks after k wait cycles; k random unless fix_k is set.
    initial begin
        int k;
        bit busy;
        k = 0;
        busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!resp_en) begin
                mem_ack = force_ack;
                busy = 1'b0;
            end else if (mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    k = (fix_k >= 0) ? fix_k : int'($urandom_range(0, 3));
                end
                if (k == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_arr[mem_addr[9:2]];
                    if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
                end else begin
                    k--;
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                mem_ack = 1'b0;
                busy = 1'b0;
            end
        end
    end

    // Monitor: predicts each grant from the request lines seen in the idle cycle
    // and pops the scoreboard on every ready pulse.
    initial begin
        bit          p_ifreq, p_dreq, p_memreq, p_ack, p_ifrdy, p_drdy, last_is_d;
        int          bypass;
        logic [31:0] last_d;
        dexp_t       de;
        logic [31:0] ie;
        bit          pick_d;
        {p_ifreq, p_dreq, p_memreq, p_ack, p_ifrdy, p_drdy, last_is_d} = '0;
        bypass = 0;
        last_d = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                {p_ifreq, p_dreq, p_memreq, p_ack, p_ifrdy, p_drdy} = '0;
                bypass = 0;
                last_d = '0;
                continue;
            end
            if (mem_req && !p_memreq) begin
                pick_d = p_dreq && !(p_ifreq && bypass >= SL);
                if (pick_d) begin
                    check("grant_d_addr", mem_addr, d_addr);
                    check("grant_d_we", mem_we, d_we);
                    check("grant_d_wdata", mem_wdata, d_wdata);
                    bypass = p_ifreq ? bypass + 1 : 0;
                end else begin
                    check("grant_i_req", p_ifreq, 1);
                    check("grant_i_addr", mem_addr, if_addr);
                    check("grant_i_we_wdata", {mem_we, mem_wdata}, 0);
                    bypass = 0;
                end
                last_is_d = pick_d;
                glog.push_back(pick_d);
                grant_cnt++;
            end
            check("ready_exclusive", if_ready & d_ready, 0);
            if (if_ready) begin
                check("if_ready_timing", {p_memreq & p_ack, last_is_d, p_ifrdy}, 3'b100);
                if (exp_if_q.size() == 0) check("if_unexpected", 1, 0);
                else begin
                    ie = exp_if_q.pop_front();
                    check("if_rdata", if_rdata, ie);
                end
            end
            if (d_ready) begin
                check("d_ready_timing", {p_memreq & p_ack, last_is_d, p_drdy}, 3'b110);
                if (exp_d_q.size() == 0) check("d_unexpected", 1, 0);
                else begin
                    de = exp_d_q.pop_front();
                    if (de.st) check("d_rdata_store_hold", d_rdata, last_d);
                    else begin
                        check("d_rdata_load", d_rdata, de.v);
                        last_d = de.v;
                    end
                end
            end
            p_ifreq = if_req;
            p_dreq = d_req;
            p_memreq = mem_req;
            p_ack = mem_ack;
            p_ifrdy = if_ready;
            p_drdy = d_ready;
        end
    end

    task automatic issue_fetch(input logic [31:0] addr);
        if_req = 1'b1;
        if_addr = addr;
        exp_if_q.push_back(ref_mem[addr[9:2]]);
    endtask

    task automatic issue_data(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        d_req = 1'b1;
        d_we = we;
        d_addr = addr;
        d_wdata = wd;
        if (we) begin
            exp_d_q.push_back('{1'b1, 32'h0});
            ref_mem[addr[9:2]] = wd;
        end else exp_d_q.push_back('{1'b0, ref_mem[addr[9:2]]});
    endtask

    // Called at posedge+1; returns at posedge+1 with the request dropped.
    task automatic do_fetch(input logic [31:0] addr);
        int n;
        issue_fetch(addr);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_ready && n < 100);
        check("fetch_complete", if_ready, 1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        issue_data(we, addr, wd);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_ready && n < 100);
        check("data_complete", d_ready, 1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    // Single isolated access with a fixed memory wait of k cycles.
    task automatic directed(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input int k, input string nm);
        int req_cycles;
        int rdy_at;
        fix_k = k;
        req_cycles = 0;
        rdy_at = -1;
        @(posedge clk);
        #1;
        if (is_d) issue_data(we, addr, wd);
        else issue_fetch(addr);
        for (int c = 0; c < 12 && rdy_at < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check({nm, "_mem_addr"}, mem_addr, addr);
                check({nm, "_mem_we"}, mem_we, is_d & we);
            end
            if (mem_req) req_cycles++;
            if (is_d ? d_ready : if_ready) rdy_at = c;
        end
        check({nm, "_ready_cycle"}, rdy_at, k + 2);
        check({nm, "_req_cycles"}, req_cycles, k + 1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check({nm, "_ready_one_cycle"}, {if_ready, d_ready}, 0);
        fix_k = -1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] gvec;
        int g;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("reset_state", {mem_req, mem_we, if_ready, d_ready}, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_rdata", {if_rdata, d_rdata}, 0);

        // Reset while a fetch waits on the memory, then a stray ack.
        resp_en = 1'b0;
        @(posedge clk);
        #1;
        issue_fetch(32'h0000_0010);
        void'(exp_if_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_memreq_before", mem_req, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        if_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_memreq", mem_req, 0);
        check("rst_mid_mem_addr", mem_addr, 0);
        check("rst_mid_flags", {mem_we, if_ready, d_ready}, 0);
        check("rst_mid_rdata", {if_rdata, d_rdata}, 0);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("late_ack_ignored", {mem_req, if_ready, d_ready}, 0);
        end
        resp_en = 1'b1;

        directed(1'b0, 1'b0, 32'h0000_0040, 32'h0, 0, "fetch_k0");
        directed(1'b1, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 2, "store_k2");
        directed(1'b1, 1'b0, 32'h0000_0080, 32'h0, 2, "load_k2");
        check("store_reached_mem", mem_arr[32], 32'hDEAD_BEEF);

        // Fetch held while data keeps re-requesting.
        pulse_reset();
        glog.delete();
        grant_cnt = 0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 2; i++) do_fetch(32'h0000_0100 + 32'(i * 4));
            end
            begin
                for (int i = 0; i < 9; i++) do_data(i[0], 32'h0000_0200 + 32'(i * 4), $urandom);
            end
`ifdef ARB_PERF_CNT_EN
            begin
                int t;
                t = 0;
                while (grant_cnt < 10 && t < 500) begin
                    @(posedge clk);
                    #2;
                    t++;
                end
                check("perf_d_grants", perf_d_grants, 8);
                check("perf_if_grants", perf_if_grants, 2);
                check("perf_conflicts", perf_conflicts, 10);
            end
`endif
        join
        gvec = '0;
        for (int i = 0; i < glog.size() && i < 11; i++) gvec[i] = glog[i];
        check("starve_grant_count", glog.size(), 11);
        check("starve_grant_order", gvec, 11'b10111101111);

        // Random traffic, random memory waits.
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    g = $urandom_range(0, 3);
                    if (g > 1) begin
                        repeat (g - 1) @(posedge clk);
                        #1;
                    end
                    do_fetch({22'h0, 1'b0, 7'($urandom_range(0, 127)), 2'b00});
                end
            end
            begin
                int gd;
                for (int i = 0; i < 50; i++) begin
                    gd = $urandom_range(0, 3);
                    if (gd > 1) begin
                        repeat (gd - 1) @(posedge clk);
                        #1;
                    end
                    do_data(1'($urandom_range(0, 1)),
                            {22'h0, 1'b1, 7'($urandom_range(0, 127)), 2'b00}, $urandom);
                end
            end
        join

        repeat (4) @(negedge clk);
        check("if_queue_drained", exp_if_q.size(), 0);
        check("d_queue_drained", exp_d_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the pipelined core's instruction-fetch port and data-memory port.
- Sequences each access as a request/ready transaction; the core stalls the affected stage while a port's ready is low.
- Data accesses have priority, with a bounded-starvation guarantee for fetch.
- Sits between mips_core (pc/instr_f, dmem_write/alu_out/dmem_write_data/dmem_read_data) and the shared memory model.

Parameters:
- STARVE_LIMIT, 4, max consecutive data grants while if_req is pending before fetch is forced to win (>=1).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  core clock; all state on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- if_req  input  1  fetch request; held with if_addr stable until if_ready
- if_addr  input  AW  fetch address (pc)
- if_rdata  output  DW  registered fetched instruction, valid while if_ready=1
- if_ready  output  1  one-cycle fetch completion pulse
- d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_ready
- d_we  input  1  1 = store, 0 = load
- d_addr  input  AW  data address (alu_out)
- d_wdata  input  DW  store data
- d_rdata  output  DW  registered load data, valid while d_ready=1
- d_ready  output  1  one-cycle data completion pulse
- mem_req  output  1  memory request; held until mem_ack
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address, registered at grant
- mem_wdata  output  DW  memory write data, registered at grant
- mem_rdata  input  DW  memory read data, valid with mem_ack
- mem_ack  input  1  memory completion; may assert in the first mem_req cycle or any later cycle

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, RESP.
- Reset (reset=0 at a clock edge): state=IDLE; mem_req, mem_we, if_ready, d_ready = 0; mem_addr, mem_wdata, if_rdata, d_rdata, starve_cnt = 0. Overrides all activity, including an in-flight access. mem_req drops the next cycle; a late mem_ack is ignored.
- IDLE, data grant: taken if d_req && !(if_req && starve_cnt==STARVE_LIMIT).
  - Latch d_addr, d_wdata, d_we into mem_*; go to GRANT_D.
  - starve_cnt increments if if_req=1, else clears.
- IDLE, fetch grant: taken otherwise, if if_req.
  - Latch if_addr; mem_we=0, mem_wdata=0; go to GRANT_I; starve_cnt clears.
- IDLE with no request: stay in IDLE; mem_req=0.
- GRANT_I / GRANT_D: mem_req=1.
  - Without mem_ack: stay; mem_* stay stable.
  - On mem_ack: drop mem_req at the next edge and go to RESP.
  - Capture mem_rdata into if_rdata (fetch) or d_rdata (load). A store leaves d_rdata unchanged.
- RESP: exactly one of if_ready / d_ready = 1 for one cycle, then go to IDLE unconditionally. The requester must drop req (or present a new transaction) by the following cycle. Requests seen in RESP are not sampled.
- Latency:
  - Request sampled in IDLE at cycle 0; mem_req high from cycle 1; mem_ack at cycle 1+k (k>=0); ready at cycle 2+k.
  - Minimum 3 cycles req->ready.
  - Back-to-back throughput: one access per 3+k cycles (IDLE, GRANT, RESP).
- mem_ack outside GRANT_I/GRANT_D: ignored.
- Requesters dropping req before ready: undefined requester protocol violation; the arbiter still completes the access and pulses ready.
- if_ready and d_ready are never high in the same cycle.
- if_rdata and d_rdata hold their last captured value between transactions.
- starve_cnt saturates at STARVE_LIMIT. Width is $clog2(STARVE_LIMIT+1).

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, adds three output ports, each 32 bits and reset to 0:
  - perf_if_grants: increments on each fetch grant.
  - perf_d_grants: increments on each data grant.
  - perf_conflicts: increments on each IDLE cycle where if_req && d_req.
- Counters wrap at 2^32.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset mid-access: grant fetch, hold mem_ack=0, assert reset=0 for 1 cycle -> next cycle mem_req=0, state IDLE, all outputs 0. A mem_ack=1 pulse afterwards produces no ready.
2. Single fetch, zero wait: if_req=1, if_addr=0x0000_0040; memory acks in the first mem_req cycle with 0x2008_0005 -> mem_addr=0x40 and mem_we=0 at cycle 1; if_rdata=0x2008_0005 and if_ready=1 at cycle 2 only.
3. Store then load, k=2: store d_addr=0x80, d_wdata=0xDEAD_BEEF -> mem_we=1, mem_req high 3 cycles, d_ready at cycle 4. Then load 0x80 with mem_rdata=0xDEAD_BEEF -> d_rdata=0xDEAD_BEEF.
4. Simultaneous requests: if_req=d_req=1 in IDLE -> data granted first (mem_addr=d_addr), fetch granted in the IDLE after RESP.
5. Starvation: if_req held high, d_req continuously re-asserted, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 fetch grant, then data again.
6. With ARB_PERF_CNT_EN: run scenario 5 for 10 grants -> perf_d_grants=8, perf_if_grants=2, perf_conflicts=10.
